fuzzifier_dt: RTL and testbench
===============================

FUZZIFIER_DT -- requirements
Module: fuzzifier_dt

Interface
- REQ-001: Port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
- REQ-002: Port rst, input, 1 bit, synchronous active-high reset; it SHALL be sampled only on the rising edge of clk.
- REQ-003: Port in_valid, input, 1 bit, SHALL qualify x and all parameter inputs in the same cycle.
- REQ-004: Port x, input, 8 bits, signed Q7.0 temperature-derivative sample.
- REQ-005: Ports a_neg, b_neg, c_neg, d_neg, input, 8 bits each, signed Q7.0, the NEG trapezoid breakpoints.
- REQ-006: Ports a_zero, b_zero, c_zero, d_zero, input, 8 bits each, signed Q7.0, the ZERO trapezoid breakpoints.
- REQ-007: Ports a_pos, b_pos, c_pos, d_pos, input, 8 bits each, signed Q7.0, the POS trapezoid breakpoints.
- REQ-008: Ports mu_neg, mu_zero, mu_pos, output, 16 bits each, unsigned Q1.15 membership degrees in the range 0 to 0x7FFF, registered.
- REQ-009: Port out_valid, output, 1 bit, SHALL be high in the cycle that the mu_* outputs hold a new result.
- REQ-010: Port param_err, output, 1 bit, registered; this port SHALL be present only when FUZZIFIER_DT_PARAM_CHECK_EN is defined.

Function
- REQ-011: The three membership functions SHALL use identical arithmetic and SHALL be computed concurrently from the same x.
- REQ-012: For a trapezoid (a, b, c, d), the first matching rule below SHALL give mu.
  - Rule 1: if x <= a or x >= d, mu = 0.
  - Rule 2: else if b <= x <= c, mu = 0x7FFF.
  - Rule 3: else if a < x < b, mu = ((x-a) << 15) / (b-a).
  - Rule 4: otherwise, mu = ((d-x) << 15) / (d-c).
- REQ-013: All comparisons SHALL be signed 8-bit comparisons.
- REQ-014: Differences SHALL be computed sign-extended to 9 bits, and each numerator SHALL be a zero-extended 24-bit value shifted left by 15.
- REQ-015: Division SHALL be unsigned and truncating (floor); a divisor equal to 0 SHALL be replaced by 1.
- REQ-016: The quotient SHALL be saturated to 0x7FFF; a mu value above 0x7FFF SHALL never appear on an output.
- REQ-017: A triangle (b = c) SHALL give 0x7FFF exactly at x = b.
- REQ-018: Rule 1 SHALL take precedence when breakpoints coincide (for example, x = a = b gives 0).
- REQ-019: Latency SHALL be exactly 1 cycle: when in_valid is high at edge N, the mu_* outputs SHALL be updated at edge N and out_valid SHALL be high during cycle N+1.
- REQ-020: The mu_* outputs SHALL hold their value while in_valid is low; out_valid SHALL then be 0.
- REQ-021: Back-to-back samples SHALL be accepted at full throughput, one sample per cycle, with no stall.

Reset
- REQ-022: When rst is high at a clock edge, mu_neg, mu_zero, mu_pos, out_valid and param_err SHALL all become 0.
- REQ-023: rst SHALL take priority over a simultaneous in_valid; a sample presented in a reset cycle SHALL be discarded.
- REQ-024: On the first edge after rst deasserts, a sample with in_valid high SHALL be processed normally.

Configuration
- REQ-025: With FUZZIFIER_DT_PARAM_CHECK_EN defined, param_err SHALL register, alongside the mu_* outputs, a 1 when any trapezoid violates a <= b <= c <= d; the mu_* values SHALL be unaffected.
- REQ-026: Without FUZZIFIER_DT_PARAM_CHECK_EN, the param_err port and its check logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-027: Use the default parameters NEG (-100,-50,-30,-5), ZERO (-10,0,0,10), POS (5,25,35,60); x = -128 and x = 127 -> all mu = 0.
- REQ-028: Defaults, x = -60 -> mu_neg = 26214, mu_zero = 0, mu_pos = 0; x = 50 -> mu_pos = 13107, mu_neg = 0, mu_zero = 0.
- REQ-029: Defaults, x = -5 -> mu_neg = 0, mu_zero = 16384, mu_pos = 0; x = 0 -> mu_zero = 32767, mu_neg = 0, mu_pos = 0.
- REQ-030: Defaults, x = -40 -> mu_neg = 32767 (plateau), mu_zero = 0, mu_pos = 0; x = 10 -> mu_zero = 0, mu_pos = 8192.
- REQ-031: Assert rst while in_valid is high mid-stream -> the next cycle shows all outputs 0; the first sample after reset appears 1 cycle later with correct values.
- REQ-032: With FUZZIFIER_DT_PARAM_CHECK_EN defined, POS = (30,20,35,60) -> param_err = 1; with the default parameters -> param_err = 0.
- REQ-033: Random ordered parameters with 40 random x values -> every output SHALL match a bit-accurate model of REQ-012 to REQ-016, and no output SHALL exceed 0x7FFF.

Source files
------------

// File: rtl/fuzzifier_dt.sv
// +--------------------------------------------------------------------------+
// | fuzzifier_dt                                                             |
// | Three-set (NEG/ZERO/POS) trapezoidal fuzzifier for a signed Q7.0 input,  |
// | single-cycle latency, Q1.15 membership outputs.                          |
// | Optional: FUZZIFIER_DT_PARAM_CHECK_EN adds the param_err output.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fuzzifier_dt (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic signed [7:0] x,
  input  logic signed [7:0] a_neg,
  input  logic signed [7:0] b_neg,
  input  logic signed [7:0] c_neg,
  input  logic signed [7:0] d_neg,
  input  logic signed [7:0] a_zero,
  input  logic signed [7:0] b_zero,
  input  logic signed [7:0] c_zero,
  input  logic signed [7:0] d_zero,
  input  logic signed [7:0] a_pos,
  input  logic signed [7:0] b_pos,
  input  logic signed [7:0] c_pos,
  input  logic signed [7:0] d_pos,
  output logic [15:0]       mu_neg,
  output logic [15:0]       mu_zero,
  output logic [15:0]       mu_pos,
  output logic              out_valid
`ifdef FUZZIFIER_DT_PARAM_CHECK_EN
  ,
  output logic              param_err
`endif
);

  // Rules are evaluated in priority order, so coincident breakpoints resolve to 0.
  function automatic logic [15:0] trap_mu(
    input logic signed [7:0] xv,
    input logic signed [7:0] a,
    input logic signed [7:0] b,
    input logic signed [7:0] c,
    input logic signed [7:0] d
  );
    logic signed [8:0] dn;
    logic signed [8:0] dd;
    logic [23:0]       num;
    logic [23:0]       den;
    logic [23:0]       q;
    logic [15:0]       mu;
    mu = 16'h0000;
    dn = 9'sd0;
    dd = 9'sd0;
    num = 24'h0;
    den = 24'h1;
    q = 24'h0;
    if (xv <= a || xv >= d) begin
      mu = 16'h0000;
    end else if (xv >= b && xv <= c) begin
      mu = 16'h7FFF;
    end else begin
      if (xv < b) begin
        dn = {xv[7], xv} - {a[7], a};
        dd = {b[7], b} - {a[7], a};
      end else begin
        dn = {d[7], d} - {xv[7], xv};
        dd = {d[7], d} - {c[7], c};
      end
      num = {15'b0, dn} << 15;
      den = {15'b0, dd};
      if (den == 24'h0) den = 24'h1;
      q = num / den;
      mu = (q > 24'h007FFF) ? 16'h7FFF : q[15:0];
    end
    return mu;
  endfunction

  logic [15:0] mu_neg_q, mu_zero_q, mu_pos_q;
  logic [15:0] mu_neg_d, mu_zero_d, mu_pos_d;
  logic        out_valid_q;

  always_comb begin
    mu_neg_d  = trap_mu(x, a_neg,  b_neg,  c_neg,  d_neg);
    mu_zero_d = trap_mu(x, a_zero, b_zero, c_zero, d_zero);
    mu_pos_d  = trap_mu(x, a_pos,  b_pos,  c_pos,  d_pos);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mu_neg_q    <= 16'h0000;
      mu_zero_q   <= 16'h0000;
      mu_pos_q    <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        mu_neg_q  <= mu_neg_d;
        mu_zero_q <= mu_zero_d;
        mu_pos_q  <= mu_pos_d;
      end
    end
  end

  assign mu_neg    = mu_neg_q;
  assign mu_zero   = mu_zero_q;
  assign mu_pos    = mu_pos_q;
  assign out_valid = out_valid_q;

`ifdef FUZZIFIER_DT_PARAM_CHECK_EN
  logic param_err_q;
  logic param_err_d;

  // Any trapezoid whose breakpoints are not non-decreasing flags an error.
  always_comb begin
    param_err_d = !(a_neg  <= b_neg  && b_neg  <= c_neg  && c_neg  <= d_neg)  ||
                  !(a_zero <= b_zero && b_zero <= c_zero && c_zero <= d_zero) ||
                  !(a_pos  <= b_pos  && b_pos  <= c_pos  && c_pos  <= d_pos);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      param_err_q <= 1'b0;
    end else if (in_valid) begin
      param_err_q <= param_err_d;
    end
  end

  assign param_err = param_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fuzzifier_dt.sv
// +--------------------------------------------------------------------------+
// | tb_fuzzifier_dt                                                          |
// | Directed and randomized self-checking bench for fuzzifier_dt.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fuzzifier_dt;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic signed [7:0] x;
  logic signed [7:0] a_neg, b_neg, c_neg, d_neg;
  logic signed [7:0] a_zero, b_zero, c_zero, d_zero;
  logic signed [7:0] a_pos, b_pos, c_pos, d_pos;
  logic [15:0]       mu_neg, mu_zero, mu_pos;
  logic              out_valid;
`ifdef FUZZIFIER_DT_PARAM_CHECK_EN
  logic              param_err;
`endif

  int checks;
  int failures;

  fuzzifier_dt dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .a_neg     (a_neg),
    .b_neg     (b_neg),
    .c_neg     (c_neg),
    .d_neg     (d_neg),
    .a_zero    (a_zero),
    .b_zero    (b_zero),
    .c_zero    (c_zero),
    .d_zero    (d_zero),
    .a_pos     (a_pos),
    .b_pos     (b_pos),
    .c_pos     (c_pos),
    .d_pos     (d_pos),
    .mu_neg    (mu_neg),
    .mu_zero   (mu_zero),
    .mu_pos    (mu_pos),
    .out_valid (out_valid)
`ifdef FUZZIFIER_DT_PARAM_CHECK_EN
    ,
    .param_err (param_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference membership in plain integer arithmetic.
  function automatic int model(input int xv, input int a, input int b, input int c, input int d);
    int r;
    if (xv <= a || xv >= d)      r = 0;
    else if (xv >= b && xv <= c) r = 32767;
    else if (xv < b)             r = ((xv - a) * 32768) / ((b - a) == 0 ? 1 : (b - a));
    else                         r = ((d - xv) * 32768) / ((d - c) == 0 ? 1 : (d - c));
    if (r > 32767) r = 32767;
    return r;
  endfunction

  task automatic set_defaults();
    a_neg  = -8'sd100; b_neg  = -8'sd50; c_neg  = -8'sd30; d_neg  = -8'sd5;
    a_zero = -8'sd10;  b_zero = 8'sd0;   c_zero = 8'sd0;   d_zero = 8'sd10;
    a_pos  = 8'sd5;    b_pos  = 8'sd25;  c_pos  = 8'sd35;  d_pos  = 8'sd60;
  endtask

  // Present one sample, then check the registered result one edge later.
  task automatic step(input string tag, input int xv, input int en, input int ez, input int ep);
    x = 8'(xv);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_vld"},  {31'b0, out_valid}, 32'd1);
    chk({tag, "_neg"},  {16'b0, mu_neg},  32'(en));
    chk({tag, "_zero"}, {16'b0, mu_zero}, 32'(ez));
    chk({tag, "_pos"},  {16'b0, mu_pos},  32'(ep));
  endtask

  task automatic rnd_sorted(output logic signed [7:0] a, output logic signed [7:0] b,
                            output logic signed [7:0] c, output logic signed [7:0] d);
    int v[4];
    int t;
    for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    a = 8'(v[0]); b = 8'(v[1]); c = 8'(v[2]); d = 8'(v[3]);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    x        = 8'sd0;
    set_defaults();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_neg",  {16'b0, mu_neg},  32'd0);
    chk("rst_zero", {16'b0, mu_zero}, 32'd0);
    chk("rst_pos",  {16'b0, mu_pos},  32'd0);
    chk("rst_vld",  {31'b0, out_valid}, 32'd0);
    rst = 1'b0;

    step("xmin",  -128, 0, 0, 0);
    step("xmax",   127, 0, 0, 0);
    step("xm60",   -60, 26214, 0, 0);
    step("x50",     50, 0, 0, 13107);
    step("xm5",     -5, 0, 16384, 0);
    step("x0",       0, 0, 32767, 0);
    step("xm40",   -40, 32767, 0, 0);
    step("x10",     10, 0, 0, 8192);

    // Idle cycle: outputs hold, out_valid drops.
    x = -8'sd60;
    @(posedge clk);
    #1;
    chk("hold_vld", {31'b0, out_valid}, 32'd0);
    chk("hold_pos", {16'b0, mu_pos}, 32'd8192);

    // Coincident breakpoint x = a = b must give 0.
    a_zero = 8'sd0; b_zero = 8'sd0; c_zero = 8'sd5; d_zero = 8'sd10;
    step("coinc", 0, 0, 0, 0);
    set_defaults();

    // Back-to-back samples at full rate.
    step("b2b0", -60, 26214, 0, 0);
    step("b2b1",  50, 0, 0, 13107);

    // Reset wins over a simultaneous valid sample.
    x = 8'sd0;
    in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmid_neg",  {16'b0, mu_neg},  32'd0);
    chk("rstmid_zero", {16'b0, mu_zero}, 32'd0);
    chk("rstmid_pos",  {16'b0, mu_pos},  32'd0);
    chk("rstmid_vld",  {31'b0, out_valid}, 32'd0);
    step("postrst", -60, 26214, 0, 0);

`ifdef FUZZIFIER_DT_PARAM_CHECK_EN
    a_pos = 8'sd30; b_pos = 8'sd20; c_pos = 8'sd35; d_pos = 8'sd60;
    step("perr_x", -60, 26214, 0, 0);
    chk("perr_set", {31'b0, param_err}, 32'd1);
    set_defaults();
    step("perr_y", -60, 26214, 0, 0);
    chk("perr_clr", {31'b0, param_err}, 32'd0);
`endif

    for (int n = 0; n < 40; n++) begin
      int xv;
      rnd_sorted(a_neg, b_neg, c_neg, d_neg);
      rnd_sorted(a_zero, b_zero, c_zero, d_zero);
      rnd_sorted(a_pos, b_pos, c_pos, d_pos);
      xv = int'($urandom_range(0, 255)) - 128;
      step("rnd", xv,
           model(xv, int'(a_neg),  int'(b_neg),  int'(c_neg),  int'(d_neg)),
           model(xv, int'(a_zero), int'(b_zero), int'(c_zero), int'(d_zero)),
           model(xv, int'(a_pos),  int'(b_pos),  int'(c_pos),  int'(d_pos)));
      chk("rnd_range", {31'b0, (mu_neg[15] | mu_zero[15] | mu_pos[15])}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
